// File: rtl/byte_fifo_pkg.sv
// Shared definitions for the ROM front-end / back-end byte FIFOs.
package byte_fifo_pkg;

  localparam int FIFO_W         = 8;
  localparam int ROM_FIFO_DEPTH = 16;

  typedef logic [FIFO_W-1:0] byte_t;

  // Registered status flags, grouped so they update together.
  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_flags_t;

  // Flag state a FIFO comes out of reset with.
  localparam fifo_flags_t FLAGS_RST = '{full: 1'b0, empty: 1'b1,
                                        almost_full: 1'b0, almost_empty: 1'b1};

  // True for 1, 2, 4, 8, ...
  function automatic bit is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/byte_fifo_ram.sv
// Simple dual-port storage: one write port, one registered read port.
// Contents are never reset; only the read register has a reset value.
module byte_fifo_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_re,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  // Write port; a same-edge read of the same address still sees the old word.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Registered read port; holds its value between accepted reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/byte_fifo.sv
// Synchronous byte FIFO between the ROM front-end and back-end.
// Pointers carry an extra wrap bit; count and all flags are registered and
// computed from the next-state pointers so they move on the same edge.
module byte_fifo
  import byte_fifo_pkg::*;
#(
  parameter int WIDTH     = FIFO_W,
  parameter int DEPTH     = ROM_FIFO_DEPTH,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         din,
  output logic                     almost_full,
  output logic                     full,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         dout,
  output logic                     almost_empty,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] AF_T = PW'(AF_THRESH);
  localparam logic [PW-1:0] AE_T = PW'(AE_THRESH);

  // Elaboration-time parameter legality.
  if (!is_pow2(DEPTH) || DEPTH < 4) begin : g_bad_depth
    $error("byte_fifo: DEPTH must be a power of 2 and >= 4");
  end
  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
    $error("byte_fifo: AF_THRESH must lie in 1..DEPTH");
  end
  if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
    $error("byte_fifo: AE_THRESH must lie in 0..DEPTH-1");
  end

  logic [PW-1:0] r_wr_ptr, r_rd_ptr, r_count;
  fifo_flags_t   r_flags;
  logic          r_ovf, r_udf;

  logic          w_rd_ok, w_wr_ok;
  logic [PW-1:0] w_wr_ptr_nxt, w_rd_ptr_nxt, w_cnt_nxt;
  fifo_flags_t   w_flags_nxt;

  // Acceptance on pre-edge state; a full FIFO takes a write only alongside a read.
  always_comb begin
    w_rd_ok = rd_en & ~r_flags.empty;
    w_wr_ok = wr_en & (~r_flags.full | w_rd_ok);
  end

  // Next pointers, occupancy and flags.
  always_comb begin
    w_wr_ptr_nxt = r_wr_ptr + {{AW{1'b0}}, w_wr_ok};
    w_rd_ptr_nxt = r_rd_ptr + {{AW{1'b0}}, w_rd_ok};
    w_cnt_nxt    = w_wr_ptr_nxt - w_rd_ptr_nxt;
    w_flags_nxt              = FLAGS_RST;
    w_flags_nxt.full         = (w_wr_ptr_nxt[AW-1:0] == w_rd_ptr_nxt[AW-1:0]) &&
                               (w_wr_ptr_nxt[AW] != w_rd_ptr_nxt[AW]);
    w_flags_nxt.empty        = (w_wr_ptr_nxt == w_rd_ptr_nxt);
    w_flags_nxt.almost_full  = (w_cnt_nxt >= AF_T);
    w_flags_nxt.almost_empty = (w_cnt_nxt <= AE_T);
  end

  // Pointer, count and flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_flags  <= FLAGS_RST;
    end else begin
      r_wr_ptr <= w_wr_ptr_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_count  <= w_cnt_nxt;
      r_flags  <= w_flags_nxt;
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      if (wr_en & ~w_wr_ok) r_ovf <= 1'b1;
      if (rd_en & r_flags.empty) r_udf <= 1'b1;
    end
  end

  byte_fifo_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_wr_ok),
    .i_waddr (r_wr_ptr[AW-1:0]),
    .i_wdata (din),
    .i_re    (w_rd_ok),
    .i_raddr (r_rd_ptr[AW-1:0]),
    .o_rdata (dout)
  );

  assign count        = r_count;
  assign full         = r_flags.full;
  assign empty        = r_flags.empty;
  assign almost_full  = r_flags.almost_full;
  assign almost_empty = r_flags.almost_empty;
  assign overflow     = r_ovf;
  assign underflow    = r_udf;

endmodule

// File: tb/tb_byte_fifo.sv
// Directed bench for byte_fifo: a vector table for fill/overflow/drain plus
// hand-written sequences for the multi-cycle corner cases.
module tb_byte_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en, rd_en;
  logic [7:0] din;
  logic [7:0] dout;
  logic [4:0] count;
  logic       almost_full, full, almost_empty, empty, overflow, underflow;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  byte_fifo dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .din          (din),
    .almost_full  (almost_full),
    .full         (full),
    .rd_en        (rd_en),
    .dout         (dout),
    .almost_empty (almost_empty),
    .empty        (empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  // Expected flag vector {full, empty, almost_full, almost_empty, overflow, underflow}.
  function automatic logic [5:0] flg(input int c, input bit ovf, input bit udf);
    return {c == 16, c == 0, c >= 14, c <= 0, ovf, udf};
  endfunction

  typedef struct {
    logic       wr;
    logic       rd;
    logic [7:0] din;
    logic [7:0] e_dout;
    logic [4:0] e_cnt;
    logic [5:0] e_flg;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic [7:0] e_dout,
                         input logic [4:0] e_cnt, input logic [5:0] e_flg);
    chk({nm, ".dout"},  {24'd0, dout}, {24'd0, e_dout});
    chk({nm, ".count"}, {27'd0, count}, {27'd0, e_cnt});
    chk({nm, ".flags"}, {26'd0, full, empty, almost_full, almost_empty, overflow, underflow},
        {26'd0, e_flg});
  endtask

  // One clock: drive at the falling edge, sample 1 ns after the rising edge.
  task automatic step(input logic w, input logic r, input logic [7:0] d);
    @(negedge clk);
    wr_en = w; rd_en = r; din = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0; din = 8'h00;
    rst = 1'b1;
    #2 rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; din = 8'h00;

    // Table: fill 0x00..0x0F, overflow attempt with 0xAA, drain 16.
    for (int i = 0; i < 16; i++)
      vq.push_back('{1'b1, 1'b0, 8'(i), 8'h00, 5'(i + 1), flg(i + 1, 0, 0)});
    vq.push_back('{1'b1, 1'b0, 8'hAA, 8'h00, 5'd16, flg(16, 1, 0)});
    for (int j = 0; j < 16; j++)
      vq.push_back('{1'b0, 1'b1, 8'h00, 8'(j), 5'(15 - j), flg(15 - j, 1, 0)});

    repeat (2) @(negedge clk);
    chk_all("reset", 8'h00, 5'd0, flg(0, 0, 0));
    rst = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].wr, vq[i].rd, vq[i].din);
      chk_all($sformatf("vec%0d", i), vq[i].e_dout, vq[i].e_cnt, vq[i].e_flg);
    end
    step(1'b0, 1'b0, 8'h00);
    chk_all("drained_idle", 8'h0F, 5'd0, flg(0, 1, 0));

    // Reset clears sticky overflow; underflow on a fresh FIFO.
    do_reset();
    #1 chk_all("reset2", 8'h00, 5'd0, flg(0, 0, 0));
    step(1'b0, 1'b1, 8'h00);
    chk_all("underflow", 8'h00, 5'd0, flg(0, 0, 1));

    // Simultaneous read/write on a full FIFO: 0x55 goes in, comes out last.
    do_reset();
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'(8'h10 + i));
    chk_all("refill", 8'h00, 5'd16, flg(16, 0, 0));
    step(1'b1, 1'b1, 8'h55);
    chk_all("rw_full", 8'h10, 5'd16, flg(16, 0, 0));
    for (int k = 1; k < 16; k++) begin
      step(1'b0, 1'b1, 8'h00);
      chk_all($sformatf("rw_drain%0d", k), 8'(8'h10 + k), 5'(16 - k), flg(16 - k, 0, 0));
    end
    step(1'b0, 1'b1, 8'h00);
    chk_all("rw_last", 8'h55, 5'd0, flg(0, 0, 0));

    // Simultaneous read/write on an empty FIFO: write lands, read rejected.
    step(1'b1, 1'b1, 8'h77);
    chk_all("rw_empty", 8'h55, 5'd1, flg(1, 0, 1));
    step(1'b0, 1'b1, 8'h00);
    chk_all("rw_empty_rd", 8'h77, 5'd0, flg(0, 0, 1));

    // Wrap-around: 40 cycles of alternating write/read across the pointer wrap.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b0, 8'(8'h40 + i));
      chk($sformatf("wrap_wcnt%0d", i), {27'd0, count}, 32'd1);
      step(1'b0, 1'b1, 8'h00);
      chk($sformatf("wrap_dout%0d", i), {24'd0, dout}, {24'd0, 8'(8'h40 + i)});
      chk($sformatf("wrap_rcnt%0d", i), {27'd0, count}, 32'd0);
    end
    chk_all("wrap_end", 8'h53, 5'd0, flg(0, 0, 0));

    // Reset mid-stream, asserted between edges, must act immediately.
    do_reset();
    step(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 8'(8'h81 + i));
    step(1'b0, 1'b1, 8'h00);
    chk_all("pre_rst", 8'h81, 5'd9, flg(9, 0, 1));
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0;
    #2 rst = 1'b1;
    #1 chk_all("async_rst", 8'h00, 5'd0, flg(0, 0, 0));
    #1 rst = 1'b0;
    step(1'b1, 1'b0, 8'h33);
    chk_all("post_rst_wr", 8'h00, 5'd1, flg(1, 0, 0));
    step(1'b0, 1'b1, 8'h00);
    chk_all("post_rst_rd", 8'h33, 5'd0, flg(0, 0, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
